// File: rtl/bvh_traversal_ctrl.sv
// BVH traversal controller: depth-first walk of a node memory,
// one box test per node, leaf hits streamed out with their ranges.
module bvh_traversal_ctrl #(
  parameter int NODE_AW     = 10,
  parameter int STACK_DEPTH = 16,
  parameter int ISECT_LAT   = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ray_valid,
  output logic               ray_ready,
  input  logic [47:0]        ray_orig,
  input  logic [107:0]       ray_inv_dir,
  input  logic [31:0]        ray_range,
  output logic               node_rd_en,
  output logic [NODE_AW-1:0] node_addr,
  input  logic [95:0]        node_box,
  input  logic               node_leaf,
  input  logic [NODE_AW-1:0] node_left,
  input  logic [NODE_AW-1:0] node_right,
  input  logic [15:0]        node_prim,
  output logic [47:0]        isect_orig,
  output logic [107:0]       isect_inv_dir,
  output logic [95:0]        isect_box,
  output logic [31:0]        isect_prev_range,
  output logic               isect_stall,
  input  logic               isect_hit,
  input  logic [31:0]        isect_range,
  output logic               leaf_valid,
  input  logic               leaf_ready,
  output logic [15:0]        leaf_prim,
  output logic [31:0]        leaf_range,
  output logic               done,
  output logic               overflow,
  output logic [CNT_W-1:0]   node_count
);

  typedef enum logic [2:0] {
    IDLE, FETCH, MEM, TEST, EMIT, POP, DONE
  } state_t;

  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int LW = $clog2(ISECT_LAT + 1);

  state_t state, nxt;

  logic [47:0]        orig_q;
  logic [107:0]       inv_q;
  logic [31:0]        rng_q;
  logic [95:0]        box_q;
  logic               leaf_q;
  logic [NODE_AW-1:0] left_q;
  logic [NODE_AW-1:0] right_q;
  logic [15:0]        prim_q;
  logic [31:0]        hit_rng_q;
  logic [NODE_AW-1:0] cur;
  logic [NODE_AW-1:0] stk [STACK_DEPTH];
  logic [PW-1:0]      sp;
  logic [PW-1:0]      sp_dec;
  logic [LW-1:0]      cnt;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               last;
  logic               full;
  logic               empty;

  assign sp_dec = sp - PW'(1);
  assign last   = cnt == LW'(ISECT_LAT - 1);
  assign full   = sp == PW'(STACK_DEPTH);
  assign empty  = sp == '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt         = state;
    ray_ready   = 1'b0;
    node_rd_en  = 1'b0;
    isect_stall = 1'b1;
    leaf_valid  = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        ray_ready = 1'b1;
        if (ray_valid) nxt = FETCH;
      end
      FETCH: begin
        node_rd_en = 1'b1;
        nxt        = MEM;
      end
      MEM: nxt = TEST;
      TEST: begin
        isect_stall = 1'b0;
        if (last) begin
          if (!isect_hit)  nxt = POP;
          else if (leaf_q) nxt = EMIT;
          else             nxt = FETCH;
        end
      end
      EMIT: begin
        leaf_valid = 1'b1;
        if (leaf_ready) nxt = POP;
      end
      POP: nxt = empty ? DONE : FETCH;
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp    <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      cnt   <= '0;
      cur   <= '0;
    end else begin
      unique case (state)
        IDLE: if (ray_valid) begin
          orig_q <= ray_orig;
          inv_q  <= ray_inv_dir;
          rng_q  <= ray_range;
          sp     <= '0;
          ovf_q  <= 1'b0;
          cnt_q  <= '0;
          cur    <= '0;
        end
        MEM: begin
          box_q   <= node_box;
          leaf_q  <= node_leaf;
          left_q  <= node_left;
          right_q <= node_right;
          prim_q  <= node_prim;
          cnt     <= '0;
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        end
        TEST: begin
          cnt <= cnt + LW'(1);
          if (last && isect_hit) begin
            if (leaf_q) begin
              hit_rng_q <= isect_range;
            end else begin
              cur <= left_q;
              // a full stack loses the right subtree; flag it
              if (full) begin
                ovf_q <= 1'b1;
              end else begin
                stk[sp[IW-1:0]] <= right_q;
                sp <= sp + PW'(1);
              end
            end
          end
        end
        POP: if (!empty) begin
          cur <= stk[sp_dec[IW-1:0]];
          sp  <= sp_dec;
        end
        default: ;
      endcase
    end
  end

  assign node_addr        = cur;
  assign isect_orig       = orig_q;
  assign isect_inv_dir    = inv_q;
  assign isect_box        = box_q;
  assign isect_prev_range = rng_q;
  assign leaf_prim        = prim_q;
  assign leaf_range       = hit_rng_q;
  assign overflow         = ovf_q;
  assign node_count       = cnt_q;

endmodule
